// File: rtl/md_timestep_sequencer.sv
// rtl/md_timestep_sequencer.sv - Timestep scheduler for the MD pipeline
//
// Runs, per timestep: force phase, pipeline drain, position update, buffer swap.
// Repeats for num_steps timesteps, then pulses run_done.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, abort      launch a run (IDLE only); force return to IDLE (highest priority)
//   num_steps         timesteps to run, latched on an accepted start
//   force_go          1-cycle pulse starting the force phase of a step
//   force_done        force phase complete (looked at only in FORCE)
//   pipe_idle         force pipeline and accumulators are empty
//   pu_ready          level enable for the position-update controller
//   pu_done           position update complete (looked at only in UPDATE)
//   double_buffer     active position half; toggles once per completed step
//   step_count        completed steps in the current run
//   busy              high whenever the sequencer is not idle
//   run_done          1-cycle pulse when every step has completed
//   error             sticky watchdog flag
module md_timestep_sequencer #(
  parameter int unsigned STEP_W       = 32,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned WDOG_LIMIT   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  output logic              force_go,
  input  logic              force_done,
  input  logic              pipe_idle,
  output logic              pu_ready,
  input  logic              pu_done,
  output logic              double_buffer,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              run_done,
  output logic              error
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  // The watchdog counter only ever needs to hold 0..WDOG_LIMIT-1.
  localparam int unsigned WDOG_W  = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FORCE,
    ST_DRAIN,
    ST_UPDATE,
    ST_SWAP,
    ST_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic [STEP_W-1:0]   step_count_q, step_count_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic                force_go_q, force_go_d;
  logic                pu_ready_q, pu_ready_d;
  logic                double_buffer_q, double_buffer_d;
  logic                busy_q, busy_d;
  logic                run_done_q, run_done_d;
  logic                error_q, error_d;

  logic                wdog_expired;
  logic [STEP_W-1:0]   step_inc;

  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    step_count_d    = step_count_q;
    drain_cnt_d     = drain_cnt_q;
    wdog_cnt_d      = '0;
    force_go_d      = 1'b0;
    pu_ready_d      = pu_ready_q;
    double_buffer_d = double_buffer_q;
    run_done_d      = 1'b0;
    error_d         = error_q;
    // Expiry happens on the WDOG_LIMIT-th cycle spent in a watched state.
    wdog_expired    = (wdog_cnt_q == WDOG_LAST);
    step_inc        = step_count_q + STEP_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (num_steps != '0) begin
            target_d     = num_steps;
            step_count_d = '0;
            force_go_d   = 1'b1;
            state_d      = ST_FORCE;
          end else begin
            run_done_d = 1'b1;
          end
        end
      end
      ST_FORCE: begin
        // Progress beats a watchdog expiry landing on the same cycle.
        if (force_done) begin
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else if (wdog_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pipe_idle && (drain_cnt_q == '0)) begin
          pu_ready_d = 1'b1;
          state_d    = ST_UPDATE;
        end else if (wdog_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (!pipe_idle) begin
          // Any busy cycle restarts the consecutive-idle requirement.
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      ST_UPDATE: begin
        if (pu_done) begin
          pu_ready_d = 1'b0;
          state_d    = ST_SWAP;
        end else if (wdog_expired) begin
          pu_ready_d = 1'b0;
          error_d    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_SWAP: begin
        double_buffer_d = ~double_buffer_q;
        step_count_d    = step_inc;
        // Compare before the increment lands so step_count never wraps.
        if (step_inc == target_q) begin
          run_done_d = 1'b1;
          state_d    = ST_FINISH;
        end else begin
          force_go_d = 1'b1;
          state_d    = ST_FORCE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards any in-flight step but keeps the last committed one.
    if (abort) begin
      state_d         = ST_IDLE;
      target_d        = target_q;
      step_count_d    = step_count_q;
      drain_cnt_d     = drain_cnt_q;
      force_go_d      = 1'b0;
      pu_ready_d      = 1'b0;
      double_buffer_d = double_buffer_q;
      run_done_d      = 1'b0;
      error_d         = error_q;
    end

    // Counter restarts on every state entry and only runs in watched states.
    if ((state_d == state_q) &&
        ((state_q == ST_FORCE) || (state_q == ST_DRAIN) || (state_q == ST_UPDATE))) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      target_q        <= '0;
      step_count_q    <= '0;
      drain_cnt_q     <= '0;
      wdog_cnt_q      <= '0;
      force_go_q      <= 1'b0;
      pu_ready_q      <= 1'b0;
      double_buffer_q <= 1'b0;
      busy_q          <= 1'b0;
      run_done_q      <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      step_count_q    <= step_count_d;
      drain_cnt_q     <= drain_cnt_d;
      wdog_cnt_q      <= wdog_cnt_d;
      force_go_q      <= force_go_d;
      pu_ready_q      <= pu_ready_d;
      double_buffer_q <= double_buffer_d;
      busy_q          <= busy_d;
      run_done_q      <= run_done_d;
      error_q         <= error_d;
    end
  end

  assign force_go      = force_go_q;
  assign pu_ready      = pu_ready_q;
  assign double_buffer = double_buffer_q;
  assign step_count    = step_count_q;
  assign busy          = busy_q;
  assign run_done      = run_done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_md_timestep_sequencer.sv
// tb/tb_md_timestep_sequencer.sv - Self-checking bench for md_timestep_sequencer
module tb_md_timestep_sequencer;

  localparam int STEP_W = 16;
  localparam int DRAIN  = 4;
  localparam int WDOG   = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [STEP_W-1:0] num_steps = '0;
  logic              force_done = 1'b0;
  logic              pipe_idle = 1'b0;
  logic              pu_done = 1'b0;
  logic              force_go;
  logic              pu_ready;
  logic              double_buffer;
  logic [STEP_W-1:0] step_count;
  logic              busy;
  logic              run_done;
  logic              error;

  md_timestep_sequencer #(
    .STEP_W(STEP_W),
    .DRAIN_CYCLES(DRAIN),
    .WDOG_LIMIT(WDOG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .num_steps(num_steps),
    .force_go(force_go),
    .force_done(force_done),
    .pipe_idle(pipe_idle),
    .pu_ready(pu_ready),
    .pu_done(pu_done),
    .double_buffer(double_buffer),
    .step_count(step_count),
    .busy(busy),
    .run_done(run_done),
    .error(error)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   fg_cnt = 0;
  int   rd_cnt = 0;
  int   steps_done = 0;
  logic db_model = 1'b0;

  always @(negedge clk) begin
    if (force_go === 1'b1) fg_cnt++;
    if (run_done === 1'b1) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles spent in DRAIN: the run ends on the cycle that completes
  // DRAIN+1 consecutive idle samples (pattern padded with idle).
  function automatic int drain_len(input logic [31:0] pat, input int npat);
    int   run;
    logic b;
    run = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < npat) b = pat[i[4:0]];
      else          b = 1'b1;
      run = b ? run + 1 : 0;
      if (run == DRAIN + 1) return i + 1;
    end
    return -1;
  endfunction

  task automatic start_run(input int n);
    num_steps = STEP_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    steps_done = 0;
  endtask

  // Entered on FORCE cycle 1. flat/plat: cycle of FORCE/UPDATE on which done is sampled.
  task automatic run_step(input int flat, input int plat, input logic [31:0] pat,
                          input int npat, input bit last, input bit abort_upd);
    int k;
    int cyc;
    chk("force_go", 32'(force_go), 32'd1);
    chk("step_count_at_go", 32'(step_count), 32'(steps_done));
    chk("dbuf_at_go", 32'(double_buffer), 32'(db_model));
    for (int c = 1; c < flat; c++) begin
      pu_done   = 1'($urandom_range(0, 1));
      pipe_idle = 1'($urandom_range(0, 1));
      tick();
    end
    pu_done    = 1'b0;
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    k   = drain_len(pat, npat);
    cyc = 0;
    while (pu_ready !== 1'b1 && cyc < 100) begin
      pipe_idle = (cyc < npat) ? pat[cyc[4:0]] : 1'b1;
      tick();
      cyc++;
    end
    chk("drain_cycles", 32'(cyc), 32'(k));
    pipe_idle = 1'b0;
    for (int c = 1; c < plat; c++) begin
      force_done = 1'($urandom_range(0, 1));
      tick();
    end
    force_done = 1'b0;
    chk("pu_ready_held", 32'(pu_ready), 32'd1);
    if (abort_upd) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_pu_ready", 32'(pu_ready), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_step_count", 32'(step_count), 32'(steps_done));
      chk("abort_dbuf", 32'(double_buffer), 32'(db_model));
      return;
    end
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    chk("pu_ready_drop", 32'(pu_ready), 32'd0);
    chk("no_error", 32'(error), 32'd0);
    steps_done++;
    db_model = ~db_model;
    tick();
    if (last) begin
      chk("run_done", 32'(run_done), 32'd1);
      tick();
      chk("busy_after_run", 32'(busy), 32'd0);
      chk("final_step_count", 32'(step_count), 32'(steps_done));
      chk("final_dbuf", 32'(double_buffer), 32'(db_model));
      chk("run_done_pulse", 32'(run_done), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_force_go"}, 32'(force_go), 32'd0);
    chk({tag, "_pu_ready"}, 32'(pu_ready), 32'd0);
    chk({tag, "_dbuf"}, 32'(double_buffer), 32'd0);
    chk({tag, "_step_count"}, 32'(step_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_run_done"}, 32'(run_done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int fg0;
    int rd0;
    int cnt;
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Three steps, fixed latencies, pipeline always idle
    fg0 = fg_cnt; rd0 = rd_cnt;
    start_run(3);
    for (int s = 0; s < 3; s++) run_step(5, 10, '1, 0, s == 2, 1'b0);
    chk("t1_force_go_pulses", 32'(fg_cnt - fg0), 32'd3);
    chk("t1_run_done_pulses", 32'(rd_cnt - rd0), 32'd1);

    // Drain pattern 1,1,0,1,1,1,1
    start_run(1);
    run_step(3, 4, 32'h7B, 7, 1'b1, 1'b0);

    // Zero-step run
    fg0 = fg_cnt; rd0 = rd_cnt;
    num_steps = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_run_done", 32'(run_done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_run_done_drop", 32'(run_done), 32'd0);
    chk("zero_no_force_go", 32'(fg_cnt - fg0), 32'd0);
    chk("zero_dbuf", 32'(double_buffer), 32'(db_model));

    // Done arriving on the watchdog's final cycle wins
    start_run(1);
    run_step(WDOG, WDOG, '1, 0, 1'b1, 1'b0);

    // Watchdog in FORCE
    rd0 = rd_cnt;
    start_run(2);
    cnt = 0;
    while (error !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("wdog_cycles", 32'(cnt), 32'(WDOG));
    chk("wdog_busy", 32'(busy), 32'd0);
    chk("wdog_pu_ready", 32'(pu_ready), 32'd0);
    chk("wdog_dbuf", 32'(double_buffer), 32'(db_model));
    chk("wdog_step_count", 32'(step_count), 32'd0);
    tick();
    chk("wdog_sticky", 32'(error), 32'd1);
    chk("wdog_no_run_done", 32'(rd_cnt - rd0), 32'd0);
    start_run(1);
    chk("start_clears_error", 32'(error), 32'd0);
    run_step(2, 3, '1, 0, 1'b1, 1'b0);

    // Abort in UPDATE of step 2 of 4
    rd0 = rd_cnt;
    start_run(4);
    run_step(3, 4, '1, 0, 1'b0, 1'b0);
    run_step(3, 4, '1, 0, 1'b0, 1'b1);
    tick();
    chk("abort_no_run_done", 32'(rd_cnt - rd0), 32'd0);

    // Abort and start together in IDLE; stray done inputs in IDLE
    fg0 = fg_cnt;
    abort = 1'b1; start = 1'b1; num_steps = STEP_W'(2);
    pu_done = 1'b1; force_done = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; pu_done = 1'b0; force_done = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_start_no_go", 32'(fg_cnt - fg0), 32'd0);
    chk("stray_idle_busy", 32'(busy), 32'd0);

    // Randomised runs
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 3));
      start_run(n);
      for (int s = 0; s < n; s++)
        run_step(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)), $urandom(),
                 int'($urandom_range(0, 10)), s == n - 1, 1'b0);
    end

    // Asynchronous reset in DRAIN with double_buffer set
    if (db_model == 1'b0) begin
      start_run(1);
      run_step(2, 2, '1, 0, 1'b1, 1'b0);
    end
    start_run(2);
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    pipe_idle = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_dbuf", 32'(double_buffer), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    db_model = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Recovery run after reset
    start_run(2);
    run_step(4, 6, $urandom(), 6, 1'b0, 1'b0);
    run_step(6, 2, $urandom(), 8, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
